sub_bytes_iter: RTL and testbench

Iterative AES-128 SubBytes stage, directly upstream of ShiftRows in the round datapath. Accepts one 128-bit state, substitutes it one 32-bit column per cycle through four shared S-box instances, and presents the full substituted state with a one-cycle valid pulse in the format ShiftRows consumes. It trades 16 parallel S-boxes for 4, with a ready signal to throttle the upstream AddRoundKey stage.

---
 rtl/aes_pkg.sv | 36 +++
 rtl/aes_sbox.sv | 11 +
 rtl/sub_bytes_iter.sv | 112 +++++++++++
 tb/tb_sub_bytes_iter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative SubBytes datapath:
// FSM encodings, column geometry and the forward S-box table.
package aes_pkg;

    localparam int NB_COL = 4;
    localparam int COL_W  = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box: one byte in, substituted byte out.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = sbox_lookup(din);

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: one 32-bit column per cycle through four shared
// S-boxes, full substituted state presented with a one-cycle valid pulse.
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out
);

    state_e              state_r;
    logic [1:0]          col_r;
    logic [DATA_W-1:0]   wrk_r;
    logic [COL_W-1:0]    col_data_s;
    logic [COL_W-1:0]    sub_col_s;
    logic [DATA_W-1:0]   wrk_sub_s;
    logic                last_col_s;
    logic                accept_s;

    assign last_col_s = (col_r == 2'd3);
    // Ready while the final column is in flight so the next state can follow back-to-back
    assign ready_in   = (state_r == ST_IDLE) | ((state_r == ST_BUSY) & last_col_s);
    assign accept_s   = valid_in & ready_in;

    // Select the current column and merge its substitution back into the work state
    always_comb begin
        col_data_s = {COL_W{1'b0}};
        wrk_sub_s  = wrk_r;
        case (col_r)
            2'd0: begin
                col_data_s        = wrk_r[127:96];
                wrk_sub_s[127:96] = sub_col_s;
            end
            2'd1: begin
                col_data_s       = wrk_r[95:64];
                wrk_sub_s[95:64] = sub_col_s;
            end
            2'd2: begin
                col_data_s       = wrk_r[63:32];
                wrk_sub_s[63:32] = sub_col_s;
            end
            2'd3: begin
                col_data_s      = wrk_r[31:0];
                wrk_sub_s[31:0] = sub_col_s;
            end
            default: begin
                col_data_s = {COL_W{1'b0}};
                wrk_sub_s  = wrk_r;
            end
        endcase
    end

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .din  (col_data_s[COL_W-1-8*i -: 8]),
            .dout (sub_col_s[COL_W-1-8*i -: 8])
        );
    end

    // Column-sequencing FSM with registered result and valid pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            col_r     <= 2'd0;
            wrk_r     <= {DATA_W{1'b0}};
            valid_out <= 1'b0;
            data_out  <= {DATA_W{1'b0}};
        end else begin
            valid_out <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        wrk_r   <= data_in;
                        col_r   <= 2'd0;
                        state_r <= ST_BUSY;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (last_col_s) begin
                        data_out  <= wrk_sub_s;
                        valid_out <= 1'b1;
                        col_r     <= 2'd0;
                        // A same-cycle accept reloads the work register; the finished result is already captured
                        if (accept_s) begin
                            wrk_r   <= data_in;
                            state_r <= ST_BUSY;
                        end else begin
                            wrk_r   <= wrk_sub_s;
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        wrk_r <= wrk_sub_s;
                        col_r <= col_r + 2'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    col_r   <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Self-checking bench for sub_bytes_iter: directed FIPS-197 / boundary vectors
// plus a random scoreboard against an algebraically computed S-box.
module tb_sub_bytes_iter;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         valid_in = 1'b0;
    logic [127:0] data_in = 128'h0;
    logic         ready_in;
    logic         valid_out;
    logic [127:0] data_out;

    int errors = 0;
    int checks = 0;
    logic [7:0]   ref_tab [256];
    logic [127:0] last_res = 128'h0;

    sub_bytes_iter #(.DATA_W(128)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Reference S-box from the GF(2^8) inverse and the affine transform
    task automatic build_ref();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            ref_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] state_ref(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_tab[s[8*i +: 8]];
        return r;
    endfunction

    // Offer one state from idle, return its result, latency and ready-low cycles
    task automatic send_and_wait(input logic [127:0] d, output logic [127:0] got,
                                 output int lat, output int rdy_low);
        got = 128'h0;
        lat = -1;
        rdy_low = 0;
        valid_in = 1'b1;
        data_in  = d;
        @(posedge clk); #1;
        valid_in = 1'b0;
        data_in  = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 1; i <= 20; i++) begin
            if (ready_in == 1'b0) rdy_low++;
            @(posedge clk); #1;
            if (valid_out == 1'b1) begin
                got = data_out;
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
        checks++; if (data_out !== 128'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_out); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_in); end
        valid_in = 1'b1;
        data_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (ready_in !== 1'b0) begin errors++; $display("FAIL midblock_ready: got %b expected 0", ready_in); end
        #1 reset = 1'b0;
        #1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", valid_out); end
        checks++; if (data_out !== 128'h0) begin errors++; $display("FAIL midreset_data: got %h expected 0", data_out); end
        checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", ready_in); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", ready_in); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++; if (valid_out !== 1'b0 || data_out !== 128'h0) begin
                errors++; $display("FAIL stale_pulse: cycle %0d valid %b data %h expected 0/0", i, valid_out, data_out);
            end
        end
    endtask

    task automatic test_fips();
        logic [127:0] got;
        int lat, rl;
        send_and_wait(128'h193de3bea0f4e22b9ac68d2ae9f84808, got, lat, rl);
        checks++; if (got !== 128'hd42711aee0bf98f1b8b45de51e415230) begin errors++; $display("FAIL fips_data: got %h expected d42711aee0bf98f1b8b45de51e415230", got); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL fips_latency: got %0d expected 4", lat); end
        checks++; if (rl !== 3) begin errors++; $display("FAIL fips_ready_low: got %0d expected 3", rl); end
        @(posedge clk); #1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL fips_pulse_width: got %b expected 0", valid_out); end
        last_res = 128'hd42711aee0bf98f1b8b45de51e415230;
    endtask

    task automatic test_boundary();
        logic [127:0] vin [3];
        logic [127:0] vexp [3];
        logic [127:0] got;
        int lat, rl;
        vin[0] = {16{8'h00}}; vexp[0] = {16{8'h63}};
        vin[1] = {16{8'hff}}; vexp[1] = {16{8'h16}};
        vin[2] = {16{8'h53}}; vexp[2] = {16{8'hed}};
        for (int t = 0; t < 3; t++) begin
            send_and_wait(vin[t], got, lat, rl);
            checks++; if (got !== vexp[t] || lat !== 4) begin
                errors++; $display("FAIL boundary_%0d: got %h lat %0d expected %h lat 4", t, got, lat, vexp[t]);
            end
            last_res = vexp[t];
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] s [3];
        logic         exp_v, exp_r;
        s[0] = 128'h00112233445566778899aabbccddeeff;
        s[1] = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        s[2] = 128'hdeadbeefcafef00d0123456789abcdef;
        @(posedge clk); #1;
        for (int e = 0; e < 14; e++) begin
            valid_in = (e <= 8);
            data_in  = (e % 4 == 0 && e <= 8) ? s[e/4] : {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            exp_v = (e == 4 || e == 8 || e == 12);
            exp_r = (e % 4 == 3) || (e >= 12);
            checks++; if (valid_out !== exp_v) begin errors++; $display("FAIL b2b_valid: edge %0d got %b expected %b", e, valid_out, exp_v); end
            checks++; if (ready_in !== exp_r) begin errors++; $display("FAIL b2b_ready: edge %0d got %b expected %b", e, ready_in, exp_r); end
            if (exp_v) begin
                checks++; if (data_out !== state_ref(s[e/4-1])) begin
                    errors++; $display("FAIL b2b_data: edge %0d got %h expected %h", e, data_out, state_ref(s[e/4-1]));
                end
            end
        end
        valid_in = 1'b0;
        last_res = state_ref(s[2]);
    endtask

    task automatic test_held();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (valid_out !== 1'b0 || data_out !== last_res) begin
                errors++; $display("FAIL held: cycle %0d valid %b data %h expected 0 %h", i, valid_out, data_out, last_res);
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] q [$];
        logic [127:0] exp_d;
        logic         will_acc, exp_v;
        int cnt = 0, acc = 0, outs = 0;
        bit done = 1'b0;
        exp_d = last_res;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            if (acc < 1000 && $urandom_range(0, 2) != 0) valid_in = 1'b1;
            else valid_in = 1'b0;
            data_in  = {$urandom, $urandom, $urandom, $urandom};
            will_acc = valid_in && (cnt <= 1);
            if (will_acc) begin q.push_back(state_ref(data_in)); acc++; end
            @(posedge clk); #1;
            exp_v = (cnt == 1);
            if (cnt != 0) cnt--;
            if (will_acc) cnt = 4;
            if (exp_v) exp_d = q.pop_front();
            if (valid_out) outs++;
            checks++; if (valid_out !== exp_v) begin errors++; $display("FAIL rand_valid: cycle %0d got %b expected %b", cyc, valid_out, exp_v); end
            checks++; if (data_out !== exp_d) begin errors++; $display("FAIL rand_data: cycle %0d got %h expected %h", cyc, data_out, exp_d); end
            checks++; if (ready_in !== (cnt <= 1)) begin errors++; $display("FAIL rand_ready: cycle %0d got %b expected %b", cyc, ready_in, (cnt <= 1)); end
            if (acc == 1000 && cnt == 0) done = 1'b1;
        end
        valid_in = 1'b0;
        checks++; if (!done || outs !== 1000) begin
            errors++; $display("FAIL rand_count: accepts %0d outputs %0d expected 1000/1000", acc, outs);
        end
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL rand_pending: got %0d expected 0", q.size()); end
    endtask

    initial begin
        build_ref();
        test_reset();
        test_fips();
        test_boundary();
        test_back_to_back();
        test_held();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
